win_param: RTL and testbench
============================

Name: win_param

Overview:
Parametrised time-domain window multiplier for the FFT front end. It is the successor to the fixed 16-bit, 32-point windower, and sits between the sample source and the FFT. Each complex sample is multiplied by a real coefficient selected by its in-frame index. Coefficients live in two run-time-loadable banks (active/shadow); a bank swap is applied only at a frame boundary, and bypass and saturation reporting are provided.

Parameters:
DWIDTH, 16, width of signed real/imag data in and out
CWIDTH, 18, width of unsigned coefficient, format UQ1.(CWIDTH-1); 1.0 = 2^(CWIDTH-1)
NWIN, 32, window length (samples per frame), power of two
IWIDTH, 5, index width, equal to log2(NWIN)

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
dv_in  in  1  input sample valid
index_in  in  IWIDTH  sample position in frame; 0 marks frame start
din_real  in  DWIDTH  signed real input
din_imag  in  DWIDTH  signed imaginary input
bypass  in  1  1: coefficient forced to exactly 1.0
coef_we  in  1  write strobe to shadow bank
coef_addr  in  IWIDTH  coefficient write address
coef_data  in  CWIDTH  coefficient write data
coef_swap  in  1  single-cycle request to swap banks at next frame start
swap_pending  out  1  swap requested, not yet applied
active_bank  out  1  bank currently used for multiplication
dv_out  out  1  output valid
index_out  out  IWIDTH  index aligned with output sample
dout_real  out  DWIDTH  windowed real output
dout_imag  out  DWIDTH  windowed imaginary output
sat_out  out  1  1 when this output sample saturated (real or imag)

Behaviour:
- Reset (rstn low, async):
  - dv_out, index_out, dout_real, dout_imag, sat_out, swap_pending, active_bank all go to 0.
  - All pipeline valids clear; in-flight samples are discarded.
  - Coefficient memories are not reset.
  - Both banks power-up initialised to 1.0 (rectangular window).
- Pipeline: fixed latency 4 cycles. A sample accepted at edge t appears with dv_out=1 at edge t+4.
  - S1: register inputs; synchronous coefficient read at index_in.
  - S2: two DWIDTH x (CWIDTH+1) signed multiplies, registered.
  - S3: round and saturate.
  - S4: output register.
- No backpressure. dv_in may be any pattern, including gaps or back-to-back. Output data and index_out hold their last values while dv_out=0.
- Arithmetic, per component:
  - prod = din * coef, signed, full precision.
  - Round half up: add 2^(CWIDTH-2), then arithmetic shift right by CWIDTH-1.
  - Clamp to [-2^(DWIDTH-1), 2^(DWIDTH-1)-1]. sat_out=1 if either component clamped.
- bypass: coefficient is exactly 2^(CWIDTH-1); latency unchanged. bypass is sampled with dv_in at S1.
- Coefficient writes: coef_we writes coef_data to the shadow bank (~active_bank) at coef_addr. The active bank is never written.
- Swap FSM, states IDLE and PENDING:
  - coef_swap in IDLE -> PENDING; swap_pending=1 from the next cycle.
  - In PENDING, the first accepted sample (dv_in=1) with index_in=0 toggles active_bank on that edge and returns to IDLE. That sample and the rest of its frame use the new bank.
  - coef_swap asserted on the same cycle as an index-0 sample in IDLE: the swap does not apply to that frame; it is applied at the next frame start.
  - coef_swap while already PENDING: ignored; still a single swap.
  - index_in=0 with dv_in=0 does not trigger a swap.
- Write to the shadow bank on the cycle the swap applies: the write lands in the bank becoming active. Read-before-write: an S1 read at the same address returns the old value.
- Index wrap: index_in goes NWIN-1 -> 0 naturally. Non-sequential indices are legal; the coefficient follows index_in.

Test Plan:
1. Reset, bypass=0, initial banks. Drive din_real=+32767, din_imag=-32768, index 0..31 continuous from cycle 10 -> dv_out first high at cycle 14; outputs +32767 and -32768; index_out 0..31; sat_out=0.
2. Load shadow with coef 0.5 (65536) at all addresses, pulse coef_swap mid-frame at index 17 -> swap_pending=1. Indices 17..31 still use 1.0. From the next index 0, outputs are 16384 and -16384; active_bank=1, swap_pending=0.
3. Shadow coef at addr 3 = 2^18-1 (about 2.0), swap, din_real=+20000 at index 3 -> dout_real=+32767, sat_out=1 for that sample only. din_imag=-20000 -> -32768.
4. Rounding: coef 0.5, din_real=+3 -> +2 (1.5 rounds up); din_real=-3 -> -1 (-1.5 rounds up).
5. dv_in toggling 1,0,1,0 with bypass=1 -> dv_out mirrors the pattern delayed 4 cycles; data equals input; outputs hold during gaps.
6. rstn asserted with 3 samples in flight and swap PENDING -> dv_out=0 immediately, no stale samples emerge; swap_pending=0 and active_bank=0 after release; bank contents retained.

Source files
------------

// File: rtl/win_param.sv
// Time-domain window multiplier: complex sample times a real coefficient from a
// double-buffered bank, 4-stage pipeline with round-half-up and saturation.
module win_param #(
    parameter int unsigned DWIDTH = 16,
    parameter int unsigned CWIDTH = 18,
    parameter int unsigned NWIN   = 32,
    parameter int unsigned IWIDTH = 5
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     dv_in,
    input  logic [IWIDTH-1:0]        index_in,
    input  logic signed [DWIDTH-1:0] din_real,
    input  logic signed [DWIDTH-1:0] din_imag,
    input  logic                     bypass,
    input  logic                     coef_we,
    input  logic [IWIDTH-1:0]        coef_addr,
    input  logic [CWIDTH-1:0]        coef_data,
    input  logic                     coef_swap,
    output logic                     swap_pending,
    output logic                     active_bank,
    output logic                     dv_out,
    output logic [IWIDTH-1:0]        index_out,
    output logic signed [DWIDTH-1:0] dout_real,
    output logic signed [DWIDTH-1:0] dout_imag,
    output logic                     sat_out
);

    localparam int unsigned PWIDTH = DWIDTH + CWIDTH + 1;
    localparam logic [CWIDTH-1:0]        COEF_ONE = CWIDTH'(1) << (CWIDTH - 1);
    localparam logic signed [PWIDTH-1:0] RND      = PWIDTH'(1) << (CWIDTH - 2);
    localparam logic signed [PWIDTH-1:0] DMAX     = (PWIDTH'(1) << (DWIDTH - 1)) - PWIDTH'(1);
    localparam logic signed [PWIDTH-1:0] DMIN     = ~DMAX;

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_PENDING = 1'b1
    } swap_state_e;

    swap_state_e state, state_nxt;
    logic        swap_apply_c;
    logic        rd_bank_c;

    // Swap state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // A requested swap waits for the first valid index-0 sample
    always_comb begin
        state_nxt    = state;
        swap_apply_c = 1'b0;
        case (state)
            S_IDLE: begin
                if (coef_swap) state_nxt = S_PENDING;
            end
            S_PENDING: begin
                if (dv_in && (index_in == '0)) begin
                    swap_apply_c = 1'b1;
                    state_nxt    = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            swap_pending <= 1'b0;
            active_bank  <= 1'b0;
        end else begin
            swap_pending <= (state_nxt == S_PENDING);
            active_bank  <= active_bank ^ swap_apply_c;
        end
    end

    // The sample that triggers the swap already reads the incoming bank
    assign rd_bank_c = active_bank ^ swap_apply_c;

    // Coefficients are stored XOR 1.0 so a zero-cleared array reads as a rectangular window
    logic [CWIDTH-1:0]        coef_mem [2][NWIN];
    logic [CWIDTH-1:0]        coef_s1;
    logic signed [DWIDTH-1:0] re_s1, im_s1;
    logic [IWIDTH-1:0]        idx_s1, idx_s2, idx_s3;
    logic                     v_s1, v_s2, v_s3;

    // S1: shadow-bank write, registered coefficient read, input capture
    always_ff @(posedge clk) begin
        if (coef_we) coef_mem[~active_bank][coef_addr] <= coef_data ^ COEF_ONE;
        if (dv_in) begin
            coef_s1 <= bypass ? COEF_ONE : (coef_mem[rd_bank_c][index_in] ^ COEF_ONE);
            re_s1   <= din_real;
            im_s1   <= din_imag;
            idx_s1  <= index_in;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v_s1 <= 1'b0;
            v_s2 <= 1'b0;
            v_s3 <= 1'b0;
        end else begin
            v_s1 <= dv_in;
            v_s2 <= v_s1;
            v_s3 <= v_s2;
        end
    end

    // S2: full-precision signed multiplies
    logic signed [CWIDTH:0]   coef_ext_c;
    logic signed [PWIDTH-1:0] prod_re, prod_im;

    assign coef_ext_c = {1'b0, coef_s1};

    always_ff @(posedge clk) begin
        if (v_s1) begin
            prod_re <= PWIDTH'(re_s1) * PWIDTH'(coef_ext_c);
            prod_im <= PWIDTH'(im_s1) * PWIDTH'(coef_ext_c);
            idx_s2  <= idx_s1;
        end
    end

    // Returns {saturated, clamped value}
    function automatic logic [DWIDTH:0] clamp(input logic signed [PWIDTH-1:0] v);
        if (v > DMAX)      clamp = {1'b1, DMAX[DWIDTH-1:0]};
        else if (v < DMIN) clamp = {1'b1, DMIN[DWIDTH-1:0]};
        else               clamp = {1'b0, v[DWIDTH-1:0]};
    endfunction

    // S3: round half up, then saturate
    logic signed [PWIDTH-1:0] rnd_re_c, rnd_im_c;
    logic [DWIDTH:0]          sat_re_c, sat_im_c;
    logic signed [DWIDTH-1:0] re_s3, im_s3;
    logic                     sat_s3;

    always_comb begin
        rnd_re_c = (prod_re + RND) >>> (CWIDTH - 1);
        rnd_im_c = (prod_im + RND) >>> (CWIDTH - 1);
        sat_re_c = clamp(rnd_re_c);
        sat_im_c = clamp(rnd_im_c);
    end

    always_ff @(posedge clk) begin
        if (v_s2) begin
            re_s3  <= sat_re_c[DWIDTH-1:0];
            im_s3  <= sat_im_c[DWIDTH-1:0];
            sat_s3 <= sat_re_c[DWIDTH] | sat_im_c[DWIDTH];
            idx_s3 <= idx_s2;
        end
    end

    // S4: output register, holds between valid samples
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dv_out    <= 1'b0;
            index_out <= '0;
            dout_real <= '0;
            dout_imag <= '0;
            sat_out   <= 1'b0;
        end else begin
            dv_out <= v_s3;
            if (v_s3) begin
                index_out <= idx_s3;
                dout_real <= re_s3;
                dout_imag <= im_s3;
                sat_out   <= sat_s3;
            end
        end
    end

endmodule

// File: tb/tb_win_param.sv
// Scoreboard bench for win_param: bank model with deferred swap, bypass,
// rounding, saturation, output hold and reset flush.
`timescale 1ns/1ps
module tb_win_param;

    localparam int     DW  = 16;
    localparam int     CW  = 18;
    localparam int     NW  = 32;
    localparam int     IW  = 5;
    localparam longint ONE = 131072;

    logic                 clk = 1'b0;
    logic                 rstn = 1'b0;
    logic                 dv_in = 1'b0;
    logic [IW-1:0]        index_in = '0;
    logic signed [DW-1:0] din_real = '0;
    logic signed [DW-1:0] din_imag = '0;
    logic                 bypass = 1'b0;
    logic                 coef_we = 1'b0;
    logic [IW-1:0]        coef_addr = '0;
    logic [CW-1:0]        coef_data = '0;
    logic                 coef_swap = 1'b0;
    logic                 swap_pending, active_bank, dv_out, sat_out;
    logic [IW-1:0]        index_out;
    logic signed [DW-1:0] dout_real, dout_imag;

    win_param #(.DWIDTH(DW), .CWIDTH(CW), .NWIN(NW), .IWIDTH(IW)) dut (
        .clk(clk), .rstn(rstn), .dv_in(dv_in), .index_in(index_in),
        .din_real(din_real), .din_imag(din_imag), .bypass(bypass),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .coef_swap(coef_swap), .swap_pending(swap_pending), .active_bank(active_bank),
        .dv_out(dv_out), .index_out(index_out), .dout_real(dout_real),
        .dout_imag(dout_imag), .sat_out(sat_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint re;
        longint im;
        longint idx;
        longint sat;
        int     cyc;
    } exp_t;

    exp_t   sb[$];
    exp_t   mon_e;
    longint last_re = 0, last_im = 0, last_idx = 0;
    int     cyc = 0;
    int     n_vec = 0;
    int     n_err = 0;
    longint mbank [2][NW];
    bit     m_act = 1'b0;
    bit     m_pend = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic longint win(input longint d, input longint c, output bit sat);
        longint r;
        r   = (d * c + 65536) >>> 17;
        sat = 1'b0;
        if (r > 32767)       begin r = 32767;  sat = 1'b1; end
        else if (r < -32768) begin r = -32768; sat = 1'b1; end
        return r;
    endfunction

    function automatic int rnd16();
        logic [15:0] r;
        r = 16'($urandom);
        return int'($signed(r));
    endfunction

    // One cycle of stimulus; expected output is predicted from the bank model
    task automatic drive(input bit dv, input int idx, input int re, input int im,
                         input bit byp = 1'b0, input bit swap = 1'b0,
                         input bit we = 1'b0, input int wa = 0, input longint wd = 0);
        bit     apply, sr, si;
        longint c;
        exp_t   e;
        apply = m_pend && dv && (idx == 0);
        c     = byp ? ONE : mbank[m_act ^ apply][idx];
        if (dv) begin
            e.re  = win(longint'(re), c, sr);
            e.im  = win(longint'(im), c, si);
            e.idx = longint'(idx);
            e.sat = longint'(sr | si);
            e.cyc = cyc + 4;
            sb.push_back(e);
        end
        dv_in     = dv;
        index_in  = IW'(idx);
        din_real  = DW'(re);
        din_imag  = DW'(im);
        bypass    = byp;
        coef_swap = swap;
        coef_we   = we;
        coef_addr = IW'(wa);
        coef_data = CW'(wd);
        if (we) mbank[~m_act][wa] = wd;
        if (apply) begin
            m_act  = ~m_act;
            m_pend = 1'b0;
        end else if (swap && !m_pend) begin
            m_pend = 1'b1;
        end
        @(posedge clk);
        #1;
        dv_in     = 1'b0;
        coef_we   = 1'b0;
        coef_swap = 1'b0;
    endtask

    // Output monitor: scoreboard compare on valid, hold check otherwise
    always @(negedge clk) begin
        if (!rstn) begin
            last_re  = 0;
            last_im  = 0;
            last_idx = 0;
        end else if (dv_out) begin
            if (sb.size() == 0) begin
                check("spurious_dv_out", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("latency",   longint'(cyc), longint'(mon_e.cyc));
                check("index_out", longint'(index_out), mon_e.idx);
                check("dout_real", longint'(dout_real), mon_e.re);
                check("dout_imag", longint'(dout_imag), mon_e.im);
                check("sat_out",   longint'(sat_out), mon_e.sat);
                last_re  = mon_e.re;
                last_im  = mon_e.im;
                last_idx = mon_e.idx;
            end
        end else begin
            check("hold_real",  longint'(dout_real), last_re);
            check("hold_imag",  longint'(dout_imag), last_im);
            check("hold_index", longint'(index_out), last_idx);
        end
    end

    initial begin
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < NW; a++) mbank[b][a] = ONE;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_dv_out",       longint'(dv_out), 0);
        check("rst_swap_pending", longint'(swap_pending), 0);
        check("rst_active_bank",  longint'(active_bank), 0);
        check("rst_dout_real",    longint'(dout_real), 0);
        check("rst_index_out",    longint'(index_out), 0);
        check("rst_sat_out",      longint'(sat_out), 0);
        rstn = 1'b1;
        while (cyc < 10) begin
            @(posedge clk);
            #1;
        end

        // Rectangular window passes full-scale values unchanged
        for (int i = 0; i < NW; i++) drive(1'b1, i, 32767, -32768);

        // Load 0.5 into shadow, request swap mid-frame
        for (int i = 0; i < NW; i++) drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1, i, 65536);
        for (int i = 0; i < 17; i++) drive(1'b1, i, rnd16(), rnd16());
        drive(1'b1, 17, 1000, -1000, 1'b0, 1'b1);
        check("pending_after_req", longint'(swap_pending), 1);
        check("bank_before_frame", longint'(active_bank), 0);
        for (int i = 18; i < NW; i++) drive(1'b1, i, rnd16(), rnd16());
        drive(1'b0, 0, 0, 0);
        check("idx0_no_dv_pending", longint'(swap_pending), 1);
        drive(1'b1, 0, -32768, 32767);
        check("bank_after_swap",    longint'(active_bank), 1);
        check("pending_after_swap", longint'(swap_pending), 0);
        drive(1'b1, 1, 3, -3);
        drive(1'b1, 2, -3, 3);
        for (int i = 3; i < NW; i++) drive(1'b1, i, rnd16(), rnd16());

        // Saturating coefficient in bank 0; swap requested on an index-0 sample
        drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 3, 262143);
        drive(1'b1, 0, 5000, -5000, 1'b0, 1'b1);
        check("same_cycle_swap_bank", longint'(active_bank), 1);
        drive(1'b1, 1, rnd16(), rnd16(), 1'b0, 1'b1);
        for (int i = 2; i < NW; i++) drive(1'b1, i, rnd16(), rnd16());
        check("deferred_pending", longint'(swap_pending), 1);
        drive(1'b1, 0, 7, -7, 1'b0, 1'b0, 1'b1, 0, 98304);
        check("deferred_bank", longint'(active_bank), 0);
        drive(1'b1, 1, 1234, -1234);
        drive(1'b1, 2, 20000, -20000);
        drive(1'b1, 3, 20000, -20000);
        drive(1'b1, 4, 20000, -20000);
        drive(1'b1, 0, 30000, -30000);
        drive(1'b1, 3, 100, -16384);

        // Bypass with gaps
        for (int k = 0; k < 12; k++)
            drive(k % 2 == 0, int'($urandom_range(0, NW - 1)), rnd16(), rnd16(), 1'b1);

        // Reset with a pending swap and samples in flight
        drive(1'b0, 0, 0, 0, 1'b0, 1'b1);
        drive(1'b1, 5, rnd16(), rnd16());
        drive(1'b1, 6, rnd16(), rnd16());
        drive(1'b1, 7, rnd16(), rnd16());
        rstn = 1'b0;
        #1;
        check("rst_flush_dv_out",   longint'(dv_out), 0);
        check("rst_flush_pending",  longint'(swap_pending), 0);
        check("rst_flush_bank",     longint'(active_bank), 0);
        sb.delete();
        m_act  = 1'b0;
        m_pend = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        for (int k = 0; k < 6; k++) drive(1'b0, 0, 0, 0);
        check("post_rst_pending", longint'(swap_pending), 0);
        for (int i = 0; i < 6; i++) drive(1'b1, i, 20000, -20000);

        // Drain
        for (int k = 0; k < 6; k++) drive(1'b0, 0, 0, 0);
        check("scoreboard_drained", longint'(sb.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
